i2c_mem_slave: RTL and testbench
================================

# i2c_mem_slave

I2C target with an internal byte-addressed register memory. It responds to a single 7-bit bus address, accepts a pointer byte followed by write data, and returns memory contents on reads. It is the far-end partner of the subsystem's I2C master and shares its `sda`/`scl` bus. All bus sampling runs in the system clock domain; `scl` is never used as a clock.

## Interface
- `SLAVE_ADDR`, 7'h50: 7-bit bus address this target answers to.
- `MEM_AW`, 4: memory address width; depth = 2**MEM_AW bytes.
- `clk`  in  1  system clock; at least 20x the `scl` frequency (50 MHz vs 100 kHz nominal).
- `rst`  in  1  asynchronous, active-low reset.
- `scl`  in  1  I2C clock from the master, input only.
- `sda`  inout  1  I2C data. Driven only low (`sda_oe` pulls low) or released to 'z.
- `busy`  out  1  high from the address-match ACK until STOP or repeated START.
- `done`  out  1  one-cycle pulse on STOP that ends an addressed transaction.
- `ptr`  out  MEM_AW  current memory pointer, for debug and verification.

## Operation
- Input path: `scl` and `sda` each pass through a 2-flop synchronizer, then a rise/fall detector.
- START: `sda` falls while `scl` is high. STOP: `sda` rises while `scl` is high. Both are recognised in any state.
- Data is sampled on the `scl` rise. `sda` is changed only after the `scl` fall.
- States:
  - `IDLE`
  - `ADDR`: shift 8 bits
  - `ADDR_ACK`
  - `PTR`: shift 8 bits
  - `PTR_ACK`
  - `WDATA`
  - `WDATA_ACK`
  - `RDATA`: drive 8 bits
  - `MACK`: sample the master's ACK
  - `WAIT_STOP`
- Transitions:
  - `IDLE` → `ADDR` on START.
  - `ADDR`, after 8 bits: if `{addr,rw}[7:1]==SLAVE_ADDR`, go to `ADDR_ACK` (drive low for the 9th bit). Otherwise go to `IDLE`; `sda` is never driven.
  - `ADDR_ACK` with rw=0 → `PTR`. With rw=1 → `RDATA`, loading `mem[ptr]` at the fall that ends the ACK.
  - `PTR` → `PTR_ACK`. The pointer is loaded with `byte[MEM_AW-1:0]`; upper bits are ignored.
  - `PTR_ACK` → `WDATA` → `WDATA_ACK`. `mem[ptr]` is written at the end of byte 8, then `ptr++`. `WDATA_ACK` returns to `WDATA`.
  - `RDATA` → `MACK`. On ACK (`sda` low): `ptr++`, load the next byte, return to `RDATA`. On NACK: go to `WAIT_STOP`.
- The pointer wraps modulo 2**MEM_AW (15+1 → 0).
- Repeated START in any state → `ADDR`. The pointer is kept and `busy` drops.
- STOP in any state → `IDLE`. A partial byte is discarded; `sda` is released.
- Reset: all state, the pointer and every memory byte clear to 0. `sda` is released asynchronously. Outputs `busy`=0, `done`=0, `ptr`=0.

## Timing
- Detection latency is 2 `clk` from a pin edge to the detected event (4 with the filter enabled).
- ACK or read-data drive: `sda_oe` updates within 1 `clk` of the detected `scl` fall.
- Release after the 9th bit: within 1 `clk` of the detected `scl` fall.
- A memory write completes on the `clk` after the 8th-bit rise is detected. The written byte is readable in the same transaction.
- `done` is asserted on the cycle after STOP detection, for exactly 1 cycle. It is not asserted for non-matching addresses.
- If START/STOP and an `scl` edge are detected in the same cycle, START/STOP wins.

## Configuration
- `I2C_SLV_GLITCH_FILTER_EN` defined:
  - Each synchronized input passes through a 3-sample majority/stability filter; the output changes only after 3 equal consecutive samples.
  - Pulses of 2 `clk` or less are rejected.
  - Adds 2 `clk` of latency.
- Undefined: raw 2-flop synchronizer output only.

## Structure
- `i2c_pkg` holds:
  - the `slv_state_t` enum;
  - `I2C_RW_READ` (1'b1);
  - `I2C_ACK` (1'b0) and `I2C_NACK` (1'b1).
- One sub-module, `i2c_sync_edge`: synchronizer, optional filter, and `rise`/`fall`/`level` outputs. It is instantiated for `scl` and for `sda`.
- Memory is a flop array, `logic [7:0] mem [2**MEM_AW]`.

## Test plan
1. Write: START, 0xA0, 0x03, 0x5A, 0xC3, STOP → four ACKs; mem[3]=0x5A, mem[4]=0xC3; `ptr`=5; one `done` pulse.
2. Read: START, 0xA0, 0x03, Sr, 0xA1, read with ACK then NACK, STOP → returns 0x5A, 0xC3; `ptr`=5; slave releases `sda` in `WAIT_STOP`.
3. Address miss: START, 0xA2, STOP → 9th bit reads high; `busy`=0 throughout; no `done`; memory unchanged.
4. Wrap: write pointer 0x0F, then data 0x11, 0x22 → mem[15]=0x11, mem[0]=0x22; `ptr`=1.
5. Abort: STOP after 4 data bits of a write → memory unchanged; `IDLE`; `done` pulses once.
6. Reset mid-read while the slave drives `sda` low → `sda`='z' with no `clk` edge; `busy`=0; mem[3]=0 afterwards.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C memory target.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        MACK,
        WAIT_STOP
    } slv_state_t;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer with rise/fall/level outputs for one I2C pin.
// Optional 3-sample stability filter selected by I2C_SLV_GLITCH_FILTER_EN.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic rise,
    output logic fall,
    output logic level
);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       w_level;

    // Idle bus level is high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], pin};
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0] r_hist;
    logic       r_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= 2'b11;
            r_hold <= 1'b1;
        end else begin
            r_hist <= {r_hist[0], r_sync[1]};
            r_hold <= w_level;
        end
    end

    // Follow the input only once three consecutive samples agree.
    assign w_level = ((r_sync[1] == r_hist[0]) && (r_hist[0] == r_hist[1]))
                     ? r_sync[1] : r_hold;
`else
    assign w_level = r_sync[1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign level = w_level;
    assign rise  = w_level & ~r_prev;
    assign fall  = ~w_level & r_prev;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C target with a byte-addressed flop memory: pointer byte, then writes or reads.
// Build option I2C_SLV_GLITCH_FILTER_EN enables the input glitch filter.
module i2c_mem_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         MEM_AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  wire               sda,
    output logic              busy,
    output logic              done,
    output logic [MEM_AW-1:0] ptr,
    output slv_state_t        state
);

    localparam int                DEPTH   = 2 ** MEM_AW;
    localparam logic [MEM_AW-1:0] PTR_ONE = 1;

    logic w_scl_rise, w_scl_fall, w_scl_lvl;
    logic w_sda_rise, w_sda_fall, w_sda_lvl;
    logic w_start, w_stop;

    i2c_sync_edge u_scl (
        .clk   (clk),
        .rst   (rst),
        .pin   (scl),
        .rise  (w_scl_rise),
        .fall  (w_scl_fall),
        .level (w_scl_lvl)
    );

    i2c_sync_edge u_sda (
        .clk   (clk),
        .rst   (rst),
        .pin   (sda),
        .rise  (w_sda_rise),
        .fall  (w_sda_fall),
        .level (w_sda_lvl)
    );

    assign w_start = w_sda_fall & w_scl_lvl;
    assign w_stop  = w_sda_rise & w_scl_lvl;

    slv_state_t        r_state, n_state;
    logic [2:0]        r_cnt, n_cnt;
    logic [6:0]        r_shift, n_shift;
    logic              r_rw, n_rw;
    logic              r_mack, n_mack;
    logic              r_oe, n_oe;
    logic              r_busy, n_busy;
    logic              r_done;
    logic [MEM_AW-1:0] r_ptr, n_ptr;
    logic [7:0]        r_mem [DEPTH];

    logic [7:0]        w_byte;
    logic [MEM_AW-1:0] w_ptr_inc;
    logic [7:0]        w_rd_cur;
    logic [7:0]        w_rd_next;
    logic              w_we;

    assign w_byte    = {r_shift, w_sda_lvl};
    assign w_ptr_inc = r_ptr + PTR_ONE;
    assign w_rd_cur  = r_mem[r_ptr];
    assign w_rd_next = r_mem[w_ptr_inc];

    always_comb begin
        n_state = r_state;
        n_cnt   = r_cnt;
        n_shift = r_shift;
        n_rw    = r_rw;
        n_mack  = r_mack;
        n_oe    = r_oe;
        n_busy  = r_busy;
        n_ptr   = r_ptr;
        w_we    = 1'b0;

        if (w_stop) begin
            n_state = IDLE;
            n_oe    = 1'b0;
            n_busy  = 1'b0;
            n_cnt   = 3'd0;
        end else if (w_start) begin
            n_state = ADDR;
            n_oe    = 1'b0;
            n_busy  = 1'b0;
            n_cnt   = 3'd0;
        end else begin
            case (r_state)
                IDLE: ;
                ADDR: begin
                    if (w_scl_rise) begin
                        n_shift = w_byte[6:0];
                        n_cnt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            n_rw = w_sda_lvl;
                            if (w_byte[7:1] == SLAVE_ADDR) begin
                                n_state = ADDR_ACK;
                                n_busy  = 1'b1;
                            end else begin
                                n_state = IDLE;
                            end
                        end
                    end
                end
                // In the ACK states r_oe marks the phase: the first fall drives
                // the ACK low, the second fall (end of bit 9) releases it.
                ADDR_ACK: begin
                    if (w_scl_fall) begin
                        n_oe  = ~r_oe;
                        n_cnt = 3'd0;
                        if (r_oe) begin
                            if (r_rw == I2C_RW_READ) begin
                                n_state = RDATA;
                                n_shift = w_rd_cur[6:0];
                                n_oe    = (w_rd_cur[7] == I2C_ACK);
                            end else begin
                                n_state = PTR;
                            end
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (w_scl_fall) begin
                        n_oe  = ~r_oe;
                        n_cnt = 3'd0;
                        if (r_oe) n_state = WDATA;
                    end
                end
                PTR: begin
                    if (w_scl_rise) begin
                        n_shift = w_byte[6:0];
                        n_cnt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            n_ptr   = w_byte[MEM_AW-1:0];
                            n_state = PTR_ACK;
                        end
                    end
                end
                WDATA: begin
                    if (w_scl_rise) begin
                        n_shift = w_byte[6:0];
                        n_cnt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_we    = 1'b1;
                            n_ptr   = w_ptr_inc;
                            n_state = WDATA_ACK;
                        end
                    end
                end
                RDATA: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 3'd7) begin
                            n_oe    = 1'b0;
                            n_cnt   = 3'd0;
                            n_state = MACK;
                        end else begin
                            n_oe    = ~r_shift[6];
                            n_shift = {r_shift[5:0], 1'b0};
                            n_cnt   = r_cnt + 3'd1;
                        end
                    end
                end
                MACK: begin
                    if (w_scl_rise) begin
                        n_mack = w_sda_lvl;
                    end else if (w_scl_fall) begin
                        n_ptr = w_ptr_inc;
                        if (r_mack == I2C_NACK) begin
                            n_state = WAIT_STOP;
                        end else begin
                            n_state = RDATA;
                            n_shift = w_rd_next[6:0];
                            n_oe    = ~w_rd_next[7];
                        end
                    end
                end
                WAIT_STOP: ;
                default: n_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_shift <= 7'd0;
            r_rw    <= 1'b0;
            r_mack  <= 1'b0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
        end else begin
            r_state <= n_state;
            r_cnt   <= n_cnt;
            r_shift <= n_shift;
            r_rw    <= n_rw;
            r_mack  <= n_mack;
            r_oe    <= n_oe;
            r_busy  <= n_busy;
            r_done  <= w_stop & r_busy;
            r_ptr   <= n_ptr;
            if (w_we) r_mem[r_ptr] <= w_byte;
        end
    end

    // Open-drain: only ever pull low; the async reset of r_oe releases the pin.
    assign sda   = r_oe ? 1'b0 : 1'bz;
    assign busy  = r_busy;
    assign done  = r_done;
    assign ptr   = r_ptr;
    assign state = r_state;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Directed bench for i2c_mem_slave: bit-banged I2C master on a pulled-up sda line.
module tb_i2c_mem_slave;
    import i2c_pkg::*;

    localparam int Q = 8;
    localparam int H = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda;
    logic       busy, done;
    logic [3:0] ptr;
    slv_state_t state;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    always #10 clk = ~clk;

    i2c_mem_slave #(.SLAVE_ADDR(7'h50), .MEM_AW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .scl   (scl_m),
        .sda   (sda),
        .busy  (busy),
        .done  (done),
        .ptr   (ptr),
        .state (state)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; scl_m = 1'b1; tick(Q);
        sda_low = 1'b1; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_rstart();
        sda_low = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_low = 1'b1; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_low = 1'b0; tick(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_low = ~b; tick(Q);
        scl_m = 1'b1; tick(H);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_low = 1'b0; tick(Q);
        scl_m = 1'b1; tick(H / 2);
        b = sda;
        tick(H / 2);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick(4);
        rst = 1'b1;
        tick(4);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (ptr !== 4'h0) begin n_err++; $display("FAIL reset_ptr: got %h want 0", ptr); end
        n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
        n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL reset_sda: got %b want 1", sda); end
    endtask

    task automatic test_write();
        logic [7:0] seq [4] = '{8'hA0, 8'h03, 8'h5A, 8'hC3};
        logic ack;
        int d0;
        d0 = done_cnt;
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(seq[i], ack);
            n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL wr_ack%0d: got %b want 0", i, ack); end
        end
        i2c_stop();
        tick(4);
        n_cmp++; if (ptr !== 4'h5) begin n_err++; $display("FAIL wr_ptr: got %h want 5", ptr); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL wr_done: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL wr_state: got %0d want %0d", state, IDLE); end
    endtask

    task automatic test_read();
        logic ack_a, ack_p, ack_r;
        logic [7:0] b0, b1;
        int d0;
        d0 = done_cnt;
        i2c_start();
        write_byte(8'hA0, ack_a);
        write_byte(8'h03, ack_p);
        i2c_rstart();
        write_byte(8'hA1, ack_r);
        read_byte(1'b0, b0);
        read_byte(1'b1, b1);
        n_cmp++; if (ack_a !== 1'b0) begin n_err++; $display("FAIL rd_ack_addr: got %b want 0", ack_a); end
        n_cmp++; if (ack_p !== 1'b0) begin n_err++; $display("FAIL rd_ack_ptr: got %b want 0", ack_p); end
        n_cmp++; if (ack_r !== 1'b0) begin n_err++; $display("FAIL rd_ack_raddr: got %b want 0", ack_r); end
        n_cmp++; if (b0 !== 8'h5A) begin n_err++; $display("FAIL rd_byte0: got %h want 5a", b0); end
        n_cmp++; if (b1 !== 8'hC3) begin n_err++; $display("FAIL rd_byte1: got %h want c3", b1); end
        n_cmp++; if (state !== WAIT_STOP) begin n_err++; $display("FAIL rd_wait_stop: got %0d want %0d", state, WAIT_STOP); end
        n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL rd_sda_released: got %b want 1", sda); end
        i2c_stop();
        tick(4);
        n_cmp++; if (ptr !== 4'h5) begin n_err++; $display("FAIL rd_ptr: got %h want 5", ptr); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL rd_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_addr_miss();
        logic ack;
        int d0, b0;
        d0 = done_cnt;
        b0 = busy_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        i2c_stop();
        tick(4);
        n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL miss_ack: got %b want 1", ack); end
        n_cmp++; if (busy_cnt - b0 !== 0) begin n_err++; $display("FAIL miss_busy: got %0d busy cycles want 0", busy_cnt - b0); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL miss_done: got %0d want 0", done_cnt - d0); end
        n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL miss_state: got %0d want %0d", state, IDLE); end
        n_cmp++; if (ptr !== 4'h5) begin n_err++; $display("FAIL miss_ptr: got %h want 5", ptr); end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [4] = '{8'hA0, 8'h0F, 8'h11, 8'h22};
        logic ack;
        logic [7:0] b0, b1;
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(seq[i], ack);
            n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL wrap_ack%0d: got %b want 0", i, ack); end
        end
        i2c_stop();
        tick(4);
        n_cmp++; if (ptr !== 4'h1) begin n_err++; $display("FAIL wrap_ptr: got %h want 1", ptr); end
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0F, ack);
        i2c_rstart();
        write_byte(8'hA1, ack);
        read_byte(1'b0, b0);
        read_byte(1'b1, b1);
        i2c_stop();
        tick(4);
        n_cmp++; if (b0 !== 8'h11) begin n_err++; $display("FAIL wrap_mem15: got %h want 11", b0); end
        n_cmp++; if (b1 !== 8'h22) begin n_err++; $display("FAIL wrap_mem0: got %h want 22", b1); end
        n_cmp++; if (ptr !== 4'h1) begin n_err++; $display("FAIL wrap_rd_ptr: got %h want 1", ptr); end
    endtask

    task automatic test_abort();
        logic ack;
        logic [7:0] b0;
        int d0;
        d0 = done_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack);
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        i2c_stop();
        tick(4);
        n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL abort_state: got %0d want %0d", state, IDLE); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL abort_done: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (ptr !== 4'h3) begin n_err++; $display("FAIL abort_ptr: got %h want 3", ptr); end
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack);
        i2c_rstart();
        write_byte(8'hA1, ack);
        read_byte(1'b1, b0);
        i2c_stop();
        tick(4);
        n_cmp++; if (b0 !== 8'h5A) begin n_err++; $display("FAIL abort_mem3: got %h want 5a", b0); end
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        logic [7:0] b0;
        int d0;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack);
        i2c_rstart();
        write_byte(8'hA1, ack);
        // mem[3] = 0x5A, so the slave is now pulling bit 7 low.
        n_cmp++; if (sda !== 1'b0) begin n_err++; $display("FAIL mid_drive: got %b want 0", sda); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
        @(posedge clk);
        #3 rst = 1'b0;
        #2;
        n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL mid_sda_release: got %b want 1", sda); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_cmp++; if (ptr !== 4'h0) begin n_err++; $display("FAIL mid_rst_ptr: got %h want 0", ptr); end
        n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL mid_rst_state: got %0d want %0d", state, IDLE); end
        tick(2);
        rst = 1'b1;
        tick(2);
        i2c_stop();
        tick(4);
        d0 = done_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack);
        i2c_rstart();
        write_byte(8'hA1, ack);
        read_byte(1'b1, b0);
        i2c_stop();
        tick(4);
        n_cmp++; if (b0 !== 8'h00) begin n_err++; $display("FAIL mid_mem3_cleared: got %h want 00", b0); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL mid_done: got %0d want 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_miss();
        test_wrap();
        test_abort();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
